// File: rtl/noc_rr_arbiter.sv
// Two-input round-robin flit arbiter with per-port FIFOs, packet locking and a registered output.
// Optional grant counters are compiled in when NOC_ARB_STATS_EN is defined.

module noc_arb_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         head_valid,
    output logic         ready
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // ready depends on the registered count alone, never on the consumer
    assign ready      = (count < FULL_CNT);
    assign head_valid = (count != '0);
    assign head       = mem[rd_ptr];
    assign do_push    = push && ready;
    assign do_pop     = pop && head_valid;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module noc_rr_arbiter #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              fclk,
    input  logic              rst,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_last,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_src,
    output logic [1:0]        arb_state
`ifdef NOC_ARB_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
`endif
);
    // Handshake: a transfer happens on a posedge where valid && ready are both high.
    // Valid never waits on ready, and a presented flit stays stable until it transfers.

    typedef enum logic [1:0] {
        ST_OPEN  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    arb_state_t      state;
    arb_state_t      state_next;
    logic [DATA_W:0] head0;
    logic [DATA_W:0] head1;
    logic            head0_valid;
    logic            head1_valid;
    logic            pop0;
    logic            pop1;
    logic            last_grant;
    logic            grant_valid;
    logic            grant_port;
    logic [DATA_W:0] sel_flit;
    logic            out_free;
    logic            load;

    noc_arb_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_fifo0 (
        .clk        (fclk),
        .rst        (rst),
        .push       (in0_valid),
        .wdata      ({in0_last, in0_data}),
        .pop        (pop0),
        .head       (head0),
        .head_valid (head0_valid),
        .ready      (in0_ready)
    );

    noc_arb_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_fifo1 (
        .clk        (fclk),
        .rst        (rst),
        .push       (in1_valid),
        .wdata      ({in1_last, in1_data}),
        .pop        (pop1),
        .head       (head1),
        .head_valid (head1_valid),
        .ready      (in1_ready)
    );

    // A locked port is the only candidate, even when it is empty and the other port waits
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = 1'b0;
        case (state)
            ST_LOCK0: begin
                grant_valid = head0_valid;
                grant_port  = 1'b0;
            end
            ST_LOCK1: begin
                grant_valid = head1_valid;
                grant_port  = 1'b1;
            end
            default: begin
                if (head0_valid && head1_valid) begin
                    grant_valid = 1'b1;
                    grant_port  = ~last_grant;
                end else if (head0_valid) begin
                    grant_valid = 1'b1;
                    grant_port  = 1'b0;
                end else if (head1_valid) begin
                    grant_valid = 1'b1;
                    grant_port  = 1'b1;
                end
            end
        endcase
    end

    assign sel_flit  = grant_port ? head1 : head0;
    assign out_free  = !out_valid || out_ready;
    assign load      = out_free && grant_valid;
    assign pop0      = load && !grant_port;
    assign pop1      = load && grant_port;
    assign arb_state = state;

    always_comb begin
        state_next = state;
        if (load) begin
            if (sel_flit[DATA_W]) begin
                state_next = ST_OPEN;
            end else begin
                state_next = grant_port ? ST_LOCK1 : ST_LOCK0;
            end
        end
    end

    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            state <= ST_OPEN;
        end else begin
            state <= state_next;
        end
    end

    // Reset value 1 makes port 0 win the first tie
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if (load) begin
            last_grant <= grant_port;
        end
    end

    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= sel_flit[DATA_W-1:0];
            out_last  <= sel_flit[DATA_W];
            out_src   <= grant_port;
        end else if (out_free) begin
            out_valid <= 1'b0;
        end
    end

`ifdef NOC_ARB_STATS_EN
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (pop0 && (grant_cnt0 != 16'hFFFF)) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (pop1 && (grant_cnt1 != 16'hFFFF)) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Scoreboard bench for noc_rr_arbiter: directed scenarios plus randomized traffic
// against a queue-based model of the arbitration rules.

module tb_noc_rr_arbiter;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;
    localparam int FW     = DATA_W + 2;

    logic              fclk = 1'b0;
    logic              rst  = 1'b0;
    logic              in0_valid = 1'b0, in1_valid = 1'b0;
    logic              in0_ready, in1_ready;
    logic [DATA_W-1:0] in0_data = '0, in1_data = '0;
    logic              in0_last = 1'b0, in1_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_src;
    logic [1:0]        arb_state;
`ifdef NOC_ARB_STATS_EN
    logic [15:0]       grant_cnt0, grant_cnt1;
`endif

    noc_rr_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .fclk      (fclk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .arb_state (arb_state)
`ifdef NOC_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    always #5 fclk = ~fclk;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    // Model: per-port pending flits {last,data}, the flit in the output slot, and the arbitration memory
    logic [DATA_W:0] q0[$];
    logic [DATA_W:0] q1[$];
    logic [FW-1:0]   exp_q[$];
    logic [FW-1:0]   got_q[$];
    bit              m_out_valid;
    bit              m_lock;
    bit              m_lock_port;
    bit              m_last_grant;
    int              m_cnt0, m_cnt1;
    bit              acc0, acc1;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        q0.delete();
        q1.delete();
        exp_q.delete();
        got_q.delete();
        m_out_valid  = 1'b0;
        m_lock       = 1'b0;
        m_lock_port  = 1'b0;
        m_last_grant = 1'b1;
        m_cnt0       = 0;
        m_cnt1       = 0;
    endfunction

    // Applies one clock edge's worth of the arbitration rules to the model
    function automatic void model_edge();
        bit push0, push1, found, gp;
        logic [DATA_W:0] f;
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (!rst) return;
        push0 = in0_valid && (q0.size() < DEPTH);
        push1 = in1_valid && (q1.size() < DEPTH);
        if (!m_out_valid || out_ready) begin
            found = 1'b0;
            gp    = 1'b0;
            if (m_lock) begin
                gp    = m_lock_port;
                found = gp ? (q1.size() > 0) : (q0.size() > 0);
            end else if (q0.size() > 0 && q1.size() > 0) begin
                gp    = !m_last_grant;
                found = 1'b1;
            end else if (q0.size() > 0) begin
                gp    = 1'b0;
                found = 1'b1;
            end else if (q1.size() > 0) begin
                gp    = 1'b1;
                found = 1'b1;
            end
            if (found) begin
                f = gp ? q1.pop_front() : q0.pop_front();
                exp_q.push_back({gp, f});
                m_out_valid  = 1'b1;
                m_last_grant = gp;
                m_lock       = !f[DATA_W];
                m_lock_port  = gp;
                if (gp) begin
                    if (m_cnt1 < 65535) m_cnt1++;
                end else begin
                    if (m_cnt0 < 65535) m_cnt0++;
                end
            end else begin
                m_out_valid = 1'b0;
            end
        end
        if (push0) q0.push_back({in0_last, in0_data});
        if (push1) q1.push_back({in1_last, in1_data});
        acc0 = push0;
        acc1 = push1;
    endfunction

    // Monitor: compares the presented flit with the scoreboard head every cycle
    always @(negedge fclk) begin
        if (mon_en && rst) begin
            chk("out_valid", out_valid, m_out_valid);
            chk("in0_ready", in0_ready, q0.size() < DEPTH);
            chk("in1_ready", in1_ready, q1.size() < DEPTH);
`ifdef NOC_ARB_STATS_EN
            chk("grant_cnt0", grant_cnt0, m_cnt0);
            chk("grant_cnt1", grant_cnt1, m_cnt1);
`endif
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_flit", {out_src, out_last, out_data}, 0);
                end else begin
                    chk("out_flit", {out_src, out_last, out_data}, exp_q[0]);
                    if (out_ready) begin
                        got_q.push_back({out_src, out_last, out_data});
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge fclk);
            model_edge();
            #2;
        end
    endtask

    task automatic idle_inputs();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_last  = 1'b0;
        in1_last  = 1'b0;
        in0_data  = '0;
        in1_data  = '0;
    endtask

    task automatic set0(input logic v, input logic [DATA_W-1:0] d, input logic l);
        in0_valid = v;
        in0_data  = d;
        in0_last  = l;
    endtask

    task automatic set1(input logic v, input logic [DATA_W-1:0] d, input logic l);
        in1_valid = v;
        in1_data  = d;
        in1_last  = l;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_src"}, out_src, 0);
        chk({tag, "_in0_ready"}, in0_ready, 1);
        chk({tag, "_in1_ready"}, in1_ready, 1);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in0_valid = 1'($urandom_range(0, 1));
            in1_valid = 1'($urandom_range(0, 1));
            in0_data  = {$urandom, $urandom};
            in1_data  = {$urandom, $urandom};
            in0_last  = 1'($urandom_range(0, 1));
            in1_last  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(posedge fclk);
            #2;
            check_reset_outputs("reset");
        end
        idle_inputs();
        model_reset();
        rst    = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic chk_got(input string name, input int k, input logic src, input logic [DATA_W-1:0] d);
        if (k >= got_q.size()) begin
            chk({name, "_missing"}, got_q.size(), k + 1);
        end else begin
            chk(name, {got_q[k][FW-1], got_q[k][DATA_W-1:0]}, {src, d});
        end
    endtask

    task automatic lock_test(input int gap);
        do_reset();
        out_ready = 1'b1;
        set1(1'b1, 64'h31, 1'b0);
        step(1);
        set1(1'b1, 64'h32, 1'b0);
        set0(1'b1, 64'h40, 1'b1);
        step(1);
        idle_inputs();
        step(gap);
        set1(1'b1, 64'h33, 1'b1);
        step(1);
        idle_inputs();
        step(6);
        chk_got("lock_f0", 0, 1'b1, 64'h31);
        chk_got("lock_f1", 1, 1'b1, 64'h32);
        chk_got("lock_f2", 2, 1'b1, 64'h33);
        chk_got("lock_f3", 3, 1'b0, 64'h40);
    endtask

    initial begin
        int i0, i1, sent;
        bit done0, done1;

        // Reset, then idle
        do_reset();
        out_ready = 1'b1;
        step(5);
        chk("idle_out_valid", out_valid, 0);

        // Single flit: two-cycle latency, one-cycle occupancy
        do_reset();
        out_ready = 1'b1;
        set0(1'b1, 64'hA5, 1'b1);
        step(1);
        idle_inputs();
        chk("single_e0_valid", out_valid, 0);
        step(1);
        chk("single_e1_valid", out_valid, 1);
        chk("single_e1_data", out_data, 64'hA5);
        chk("single_e1_src", out_src, 0);
        step(1);
        chk("single_e2_valid", out_valid, 0);

        // Fairness between two streams of single-flit packets
        do_reset();
        out_ready = 1'b1;
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 14; c++) begin
            set0(i0 < 4, DATA_W'(64'h10 + i0), 1'b1);
            set1(i1 < 4, DATA_W'(64'h20 + i1), 1'b1);
            step(1);
            if (acc0) i0++;
            if (acc1) i1++;
        end
        idle_inputs();
        step(2);
        for (int k = 0; k < 4; k++) begin
            chk_got("fair_p0", 2 * k, 1'b0, DATA_W'(64'h10 + k));
            chk_got("fair_p1", 2 * k + 1, 1'b1, DATA_W'(64'h20 + k));
        end

        // Packet lock, back-to-back and with a gap before the last flit
        lock_test(0);
        lock_test(2);

        // Full stall: DEPTH entries plus the output register
        do_reset();
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 10; c++) begin
            set0(sent < 8, DATA_W'(64'h70 + sent), 1'b1);
            step(1);
            if (acc0) sent++;
        end
        idle_inputs();
        chk("stall_accepted", sent, 5);
        chk("stall_in0_ready", in0_ready, 0);
        chk("stall_out_data", out_data, 64'h70);
        out_ready = 1'b1;
        step(7);
        for (int k = 0; k < 5; k++) begin
            chk_got("stall_drain", k, 1'b0, DATA_W'(64'h70 + k));
        end
        chk("stall_in0_ready_back", in0_ready, 1);

        // Reset in the middle of a locked packet
        do_reset();
        out_ready = 1'b1;
        set1(1'b1, 64'h51, 1'b0);
        step(1);
        set1(1'b1, 64'h52, 1'b0);
        step(1);
        set1(1'b1, 64'h53, 1'b1);
        step(1);
        idle_inputs();
        chk("midpkt_holding", out_data, 64'h52);
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        check_reset_outputs("midpkt");
        @(posedge fclk);
        #2;
        model_reset();
        rst    = 1'b1;
        mon_en = 1'b1;
        set0(1'b1, 64'h61, 1'b1);
        set1(1'b1, 64'h62, 1'b1);
        step(1);
        idle_inputs();
        step(4);
        chk_got("post_reset_first", 0, 1'b0, 64'h61);
        chk_got("post_reset_second", 1, 1'b1, 64'h62);
`ifdef NOC_ARB_STATS_EN
        chk("post_reset_cnt0", grant_cnt0, 1);
        chk("post_reset_cnt1", grant_cnt1, 1);
`endif

        // Randomized traffic with random backpressure
        do_reset();
        for (int c = 0; c < 600; c++) begin
            set0(1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(0, 2) != 0);
            set1(1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            step(1);
        end

        // Close any open packet on both ports, then drain
        out_ready = 1'b1;
        done0 = 1'b0;
        done1 = 1'b0;
        for (int c = 0; c < 60 && !(done0 && done1); c++) begin
            set0(!done0, {$urandom, $urandom}, 1'b1);
            set1(!done1, {$urandom, $urandom}, 1'b1);
            step(1);
            if (acc0) done0 = 1'b1;
            if (acc1) done1 = 1'b1;
        end
        idle_inputs();
        chk("drain_closed", {done0, done1}, 2'b11);
        step(20);
        chk("drain_exp_empty", exp_q.size(), 0);
        chk("drain_out_valid", out_valid, 0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
